alu_operand_sequencer: RTL and testbench
========================================

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 Parameter: CNT_W, 8, width of completed-operation counter op_count.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  4  serial operand/opcode nibble from upstream.
REQ-005 Port: din_valid  input  1  din holds a valid nibble.
REQ-006 Port: din_ready  output  1  sequencer accepts din this cycle.
REQ-007 Port: abort  input  1  discard partial load, return to LOAD_X.
REQ-008 Port: x  output  4  operand A to downstream ALU.
REQ-009 Port: y  output  4  operand B to downstream ALU.
REQ-010 Port: select  output  2  ALU operation code (00 add, 01 sub, 10 mul, 11 pass x).
REQ-011 Port: f  input  8  combinational ALU result for current x, y, select.
REQ-012 Port: result  output  8  captured ALU result.
REQ-013 Port: result_valid  output  1  result holds an unconsumed value.
REQ-014 Port: result_ready  input  1  consumer accepts result this cycle.
REQ-015 Port: op_count  output  CNT_W  number of results consumed, modulo 2^CNT_W.

Function
REQ-016 FSM states SHALL be LOAD_X, LOAD_Y, LOAD_SEL, ISSUE, RESULT.
REQ-017 din transfer SHALL occur on a rising edge where din_valid=1 and din_ready=1.
REQ-018 din_ready SHALL be 1 exactly in LOAD_X, LOAD_Y, LOAD_SEL with abort=0; 0 otherwise.
REQ-019 LOAD_X: on transfer, x <= din, go to LOAD_Y; else stay.
REQ-020 LOAD_Y: on transfer, y <= din, go to LOAD_SEL; else stay.
REQ-021 LOAD_SEL: on transfer, select <= din[1:0] (din[3:2] ignored), go to ISSUE; else stay.
REQ-022 ISSUE: lasts exactly one cycle; result <= f on its closing edge; go to RESULT; abort ignored in ISSUE.
REQ-023 RESULT: result_valid=1; on edge with result_ready=1, go to LOAD_X and op_count <= op_count+1; else hold result and state.
REQ-024 result_valid SHALL be 1 only in RESULT; result value SHALL stay stable from capture until next capture.
REQ-025 x, y, select SHALL change only on their own load transfer; held unchanged through ISSUE and RESULT.
REQ-026 Latency: from select-nibble transfer edge to result_valid=1 SHALL be exactly 2 rising edges.
REQ-027 abort=1 in LOAD_X/LOAD_Y/LOAD_SEL SHALL force LOAD_X next edge with no register update; x, y, select keep prior values.
REQ-028 abort=1 in RESULT SHALL be ignored; result handshake alone governs exit.
REQ-029 In RESULT, din_valid=1 SHALL not be accepted; first nibble accepted no earlier than the cycle after the result handshake.
REQ-030 op_count SHALL wrap from 2^CNT_W-1 to 0 without any flag or stall.
REQ-031 Back-to-back operation: with din_valid and result_ready held 1, one result SHALL complete every 5 cycles.

Reset
REQ-032 reset=1 SHALL immediately, independent of clk, force state LOAD_X, x=0, y=0, select=00, result=0x00, result_valid=0, op_count=0.
REQ-033 din_ready SHALL be 0 while reset=1 and become 1 on the first cycle after deassertion.
REQ-034 reset asserted mid-load or in RESULT SHALL discard the partial operation and pending result; op_count not incremented.

Verification
REQ-035 Add: din 9,7,0 with valid, ALU model connected -> result=0x10, result_valid 2 edges after third transfer, op_count 0->1 on handshake.
REQ-036 Mul with stall: din F,F,2, result_ready=0 for 10 cycles -> result=0xE1 held, result_valid=1, din_ready=0 throughout; then ready=1 -> LOAD_X.
REQ-037 Abort: din 3,5 then abort=1 while in LOAD_SEL -> LOAD_X next edge, x=3,y=5 unchanged, no result_valid; next full load 1,2,0 -> result=0x03.
REQ-038 Async reset: assert reset between edges while in RESULT -> result_valid=0, result=0x00, op_count=0 before next clk edge.
REQ-039 Wrap: CNT_W=2, four completed ops -> op_count sequence 1,2,3,0.
REQ-040 Throughput: din_valid=1, result_ready=1 constant, select=11 -> result_valid pulse every 5 cycles, result={4'b0,x}.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Serially loads x, y and select nibbles, issues them to an external ALU and holds the captured result.
// Latency: result_valid rises two edges after the select transfer edge; one result every 5 cycles back-to-back.
// Backpressure: din_ready drops outside the load states; result holds until result_ready.
module alu_operand_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic [3:0]       x,
    output logic [3:0]       y,
    output logic [1:0]       select,
    input  logic [7:0]       f,
    output logic [7:0]       result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        LOAD_X,
        LOAD_Y,
        LOAD_SEL,
        ISSUE,
        RESULT
    } state_t;

    state_t state, state_nxt;
    logic   load_rdy;
    logic   load_x, load_y, load_sel, capture, consume;

    always_comb begin
        state_nxt    = state;
        load_rdy     = 1'b0;
        load_x       = 1'b0;
        load_y       = 1'b0;
        load_sel     = 1'b0;
        capture      = 1'b0;
        consume      = 1'b0;
        result_valid = 1'b0;
        case (state)
            LOAD_X: begin
                load_rdy = !abort;
                if (abort) begin
                    state_nxt = LOAD_X;
                end else if (din_valid) begin
                    load_x    = 1'b1;
                    state_nxt = LOAD_Y;
                end
            end
            LOAD_Y: begin
                load_rdy = !abort;
                if (abort) begin
                    state_nxt = LOAD_X;
                end else if (din_valid) begin
                    load_y    = 1'b1;
                    state_nxt = LOAD_SEL;
                end
            end
            LOAD_SEL: begin
                load_rdy = !abort;
                if (abort) begin
                    state_nxt = LOAD_X;
                end else if (din_valid) begin
                    load_sel  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                capture   = 1'b1;
                state_nxt = RESULT;
            end
            RESULT: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    consume   = 1'b1;
                    state_nxt = LOAD_X;
                end
            end
            default: state_nxt = LOAD_X;
        endcase
    end

    // Reset is asynchronous, so ready must also be masked combinationally while it is held.
    assign din_ready = load_rdy & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= LOAD_X;
            x        <= 4'h0;
            y        <= 4'h0;
            select   <= 2'b00;
            result   <= 8'h00;
            op_count <= '0;
        end else begin
            state <= state_nxt;
            if (load_x)   x      <= din;
            if (load_y)   y      <= din;
            if (load_sel) select <= din[1:0];
            if (capture)  result <= f;
            if (consume)  op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench: two sequencer instances (CNT_W=8 and CNT_W=2) driven in lockstep, each fed by a behavioural ALU.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] din;
    logic       din_valid;
    logic       abort;
    logic       result_ready;

    logic       din_ready, din_ready2;
    logic [3:0] x, y, x2, y2;
    logic [1:0] select, select2;
    logic [7:0] f, f2, result, result2;
    logic       result_valid, result_valid2;
    logic [7:0] op_count;
    logic [1:0] op_count2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'b00:   return {4'h0, a} + {4'h0, b};
            2'b01:   return {4'h0, a} - {4'h0, b};
            2'b10:   return {4'h0, a} * {4'h0, b};
            default: return {4'h0, a};
        endcase
    endfunction

    assign f  = alu(x, y, select);
    assign f2 = alu(x2, y2, select2);

    alu_operand_sequencer #(.CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .abort(abort), .x(x), .y(y), .select(select), .f(f), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .op_count(op_count)
    );

    alu_operand_sequencer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready2),
        .abort(abort), .x(x2), .y(y2), .select(select2), .f(f2), .result(result2),
        .result_valid(result_valid2), .result_ready(result_ready), .op_count(op_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; din = 4'h0; din_valid = 1'b0; abort = 1'b0; result_ready = 1'b0;
        step();
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %0b want 0", din_ready); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_result_valid got %0b want 0", result_valid); end
        checks++; if ({x, y, select} !== 10'h0) begin errors++; $display("FAIL reset_xysel got %h/%h/%h want 0/0/0", x, y, select); end
        checks++; if (result !== 8'h00 || op_count !== 8'h00) begin errors++; $display("FAIL reset_result_count got %h/%0d want 00/0", result, op_count); end
        reset = 1'b0;
        step();
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b want 1", din_ready); end
    endtask

    task automatic test_add();
        din_valid = 1'b1;
        din = 4'h9; step();
        din = 4'h7; step();
        din = 4'h0; step();
        checks++; if (result_valid !== 1'b0 || din_ready !== 1'b0) begin errors++; $display("FAIL add_issue got rv=%0b rdy=%0b want 0/0", result_valid, din_ready); end
        checks++; if (x !== 4'h9 || y !== 4'h7 || select !== 2'b00) begin errors++; $display("FAIL add_operands got %h/%h/%h want 9/7/0", x, y, select); end
        din_valid = 1'b0;
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'h10) begin errors++; $display("FAIL add_result got rv=%0b %h want 1 10", result_valid, result); end
        checks++; if (op_count !== 8'd0) begin errors++; $display("FAIL add_count_before got %0d want 0", op_count); end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        checks++; if (op_count !== 8'd1 || result_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL add_handshake got cnt=%0d rv=%0b rdy=%0b want 1/0/1", op_count, result_valid, din_ready); end
    endtask

    task automatic test_mul_stall();
        din_valid = 1'b1;
        din = 4'hF; step();
        din = 4'hF; step();
        din = 4'h2; step();
        din = 4'h4;
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (result_valid !== 1'b1 || result !== 8'hE1 || din_ready !== 1'b0 || x !== 4'hF) begin
                errors++; $display("FAIL mul_stall cyc%0d got rv=%0b res=%h rdy=%0b x=%h want 1 E1 0 F", i, result_valid, result, din_ready, x);
            end
            step();
        end
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        checks++; if (din_ready !== 1'b1 || result_valid !== 1'b0 || op_count !== 8'd2 || x !== 4'hF) begin
            errors++; $display("FAIL mul_exit got rdy=%0b rv=%0b cnt=%0d x=%h want 1/0/2/F", din_ready, result_valid, op_count, x);
        end
        din_valid = 1'b0;
    endtask

    task automatic test_abort();
        din_valid = 1'b1;
        din = 4'h3; step();
        din = 4'h5; step();
        abort = 1'b1; din = 4'h0;
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %0b want 0", din_ready); end
        step();
        abort = 1'b0; din_valid = 1'b0;
        #1;
        checks++; if (x !== 4'h3 || y !== 4'h5 || select !== 2'b10) begin errors++; $display("FAIL abort_hold got %h/%h/%h want 3/5/2", x, y, select); end
        checks++; if (result_valid !== 1'b0 || din_ready !== 1'b1) begin errors++; $display("FAIL abort_state got rv=%0b rdy=%0b want 0/1", result_valid, din_ready); end
        step();
        checks++; if (din_ready !== 1'b1 || x !== 4'h3) begin errors++; $display("FAIL abort_idle got rdy=%0b x=%h want 1/3", din_ready, x); end
        din_valid = 1'b1;
        din = 4'h1; step();
        din = 4'h2; step();
        din = 4'h0; step();
        din_valid = 1'b0;
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'h03) begin errors++; $display("FAIL abort_reload got rv=%0b %h want 1 03", result_valid, result); end
        abort = 1'b1;
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'h03) begin errors++; $display("FAIL abort_in_result got rv=%0b %h want 1 03", result_valid, result); end
        result_ready = 1'b1;
        step();
        abort = 1'b0; result_ready = 1'b0;
        checks++; if (result_valid !== 1'b0 || op_count !== 8'd3) begin errors++; $display("FAIL abort_exit got rv=%0b cnt=%0d want 0/3", result_valid, op_count); end
    endtask

    task automatic test_async_reset();
        din_valid = 1'b1;
        din = 4'h5; step();
        din = 4'h3; step();
        din = 4'h1; step();
        din_valid = 1'b0;
        step();
        checks++; if (result_valid !== 1'b1 || result !== 8'h02) begin errors++; $display("FAIL sub_result got rv=%0b %h want 1 02", result_valid, result); end
        #2 reset = 1'b1;
        #1;
        checks++; if (result_valid !== 1'b0 || result !== 8'h00 || op_count !== 8'd0) begin
            errors++; $display("FAIL async_reset got rv=%0b res=%h cnt=%0d want 0 00 0", result_valid, result, op_count);
        end
        checks++; if (din_ready !== 1'b0 || x !== 4'h0 || select !== 2'b00) begin errors++; $display("FAIL async_reset_regs got rdy=%0b x=%h sel=%h want 0 0 0", din_ready, x, select); end
        #1 reset = 1'b0;
        step();
        checks++; if (din_ready !== 1'b1 || op_count2 !== 2'd0) begin errors++; $display("FAIL reset_release got rdy=%0b cnt2=%0d want 1/0", din_ready, op_count2); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] xs [4];
        logic [1:0] wrap_exp [4];
        xs = '{4'hA, 4'h3, 4'hF, 4'h6};
        wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        din_valid = 1'b1; result_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din = xs[k]; step();
            din = 4'h1; step();
            din = 4'hF; step();
            checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL b2b_issue%0d got rv=%0b want 0", k, result_valid); end
            step();
            checks++; if (result_valid !== 1'b1 || result !== {4'h0, xs[k]} || select !== 2'b11) begin
                errors++; $display("FAIL b2b_result%0d got rv=%0b res=%h sel=%h want 1 %h 3", k, result_valid, result, select, {4'h0, xs[k]});
            end
            step();
            checks++; if (op_count2 !== wrap_exp[k] || op_count !== 8'(k + 1)) begin
                errors++; $display("FAIL b2b_count%0d got cnt2=%0d cnt=%0d want %0d %0d", k, op_count2, op_count, wrap_exp[k], k + 1);
            end
        end
        din_valid = 1'b0; result_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_stall();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
